pid_core_mc: RTL and testbench

- Time-multiplexed, multi-channel successor to the single-channel PID core.
- Runs NUM_CH independent second-order IIR PID laws through one shared multiply-accumulate datapath:
  y[n] = -a1*y[n-1] - a0*y[n-2] + b2*e[n] + b1*e[n-1] + b0*e[n-2], with e = SET - ADC.
- Adds configurable output clamp limits with clamped-state anti-windup, per-channel enable, and a start/busy/done handshake.
- Sits between the ADC sampler and the fan PWM generators; one start pulse per control period.

---
 rtl/pid_core_mc_pkg.sv | 42 ++++
 rtl/pid_core_mc_if.sv | 25 ++
 rtl/pid_core_mc_mac_sat.sv | 54 +++++
 rtl/pid_core_mc.sv | 138 +++++++++++++
 tb/tb_pid_core_mc.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/pid_core_mc_pkg.sv
// Shared widths, FSM encoding and term sequencing for the multi-channel PID core.
package pid_pkg;

  localparam int NUM_CH        = 2;
  localparam int ADC_BITWIDTH  = 8;
  localparam int REG_BITWIDTH  = 8;
  localparam int FRAC_BITWIDTH = 3;
  localparam int OUT_MIN       = -256;
  localparam int OUT_MAX       = 255;

  localparam int NUM_TERMS = 5;
  localparam int E_W       = ADC_BITWIDTH + 1;
  localparam int Y_W       = ADC_BITWIDTH + 1 + FRAC_BITWIDTH;
  localparam int ACC_W     = REG_BITWIDTH + ADC_BITWIDTH + FRAC_BITWIDTH + 4;
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [2:0] TERM_B2 = 3'd0;
  localparam logic [2:0] TERM_B1 = 3'd1;
  localparam logic [2:0] TERM_B0 = 3'd2;
  localparam logic [2:0] TERM_A1 = 3'd3;
  localparam logic [2:0] TERM_A0 = 3'd4;

  // Bit offset of a term's coefficient inside one channel's {a1,a0,b2,b1,b0} word.
  function automatic int coef_lsb(input logic [2:0] term);
    case (term)
      TERM_B2: coef_lsb = 2 * REG_BITWIDTH;
      TERM_B1: coef_lsb = 1 * REG_BITWIDTH;
      TERM_B0: coef_lsb = 0;
      TERM_A1: coef_lsb = 4 * REG_BITWIDTH;
      TERM_A0: coef_lsb = 3 * REG_BITWIDTH;
      default: coef_lsb = 0;
    endcase
  endfunction

endpackage

// File: rtl/pid_core_mc_if.sv
// Start/busy/done handshake plus packed per-channel operand and result buses.
interface pid_core_mc_if;
  import pid_pkg::*;

  logic                                          start_i;
  logic [NUM_CH-1:0]                             ch_en_i;
  logic [NUM_CH*ADC_BITWIDTH-1:0]                ADC_value_i;
  logic [NUM_CH*ADC_BITWIDTH-1:0]                SET_value_i;
  logic [NUM_CH*NUM_TERMS*REG_BITWIDTH-1:0]      coef_i;
  logic                                          busy_o;
  logic                                          done_o;
  logic                                          overrun_o;
  logic [NUM_CH*E_W-1:0]                         out_Val_o;

  modport master (
    output start_i, ch_en_i, ADC_value_i, SET_value_i, coef_i,
    input  busy_o, done_o, overrun_o, out_Val_o
  );

  modport slave (
    input  start_i, ch_en_i, ADC_value_i, SET_value_i, coef_i,
    output busy_o, done_o, overrun_o, out_Val_o
  );

endinterface

// File: rtl/pid_core_mc_mac_sat.sv
// Shared multiply-accumulate (one product per cycle) with the Q(FRAC) rescale and output clamp.
module pid_mac_sat
  import pid_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  input  logic                           clr_i,
  input  logic                           is_b_i,
  input  logic signed [REG_BITWIDTH-1:0] coef_i,
  input  logic signed [Y_W-1:0]          op_i,
  output logic signed [Y_W-1:0]          y_sat_o
);

  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(OUT_MAX * (2 ** FRAC_BITWIDTH));
  localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(OUT_MIN * (2 ** FRAC_BITWIDTH));

  logic signed [ACC_W-1:0] prod_s;
  logic signed [ACC_W-1:0] term_s;
  logic signed [ACC_W-1:0] shr_s;
  logic signed [ACC_W-1:0] acc_r;

  // b-terms are aligned up to Q(2*FRAC); a-terms already are and enter negated.
  always_comb begin
    prod_s = ACC_W'(coef_i) * ACC_W'(op_i);
    if (is_b_i) begin
      term_s = prod_s <<< FRAC_BITWIDTH;
    end else begin
      term_s = -prod_s;
    end
  end

  // Accumulator register; the first term of a channel overwrites the previous sum.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (en_i) begin
      acc_r <= clr_i ? term_s : (acc_r + term_s);
    end
  end

  // Floor back to Q(FRAC) and clamp; the clamped value is what feeds back as y1.
  always_comb begin
    shr_s = acc_r >>> FRAC_BITWIDTH;
    if (shr_s > Y_MAX) begin
      y_sat_o = Y_W'(Y_MAX);
    end else if (shr_s < Y_MIN) begin
      y_sat_o = Y_W'(Y_MIN);
    end else begin
      y_sat_o = Y_W'(shr_s);
    end
  end

endmodule

// File: rtl/pid_core_mc.sv
// Time-multiplexed NUM_CH-channel IIR PID: snapshot on start, 5 MAC cycles plus 1 writeback per channel.
module pid_core_mc
  import pid_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  pid_core_mc_if.slave  bus
);

  state_e                                   state_r, state_s;
  logic [CH_W-1:0]                          ch_r;
  logic [2:0]                               term_r;
  logic [NUM_CH*ADC_BITWIDTH-1:0]           adc_r, set_r;
  logic [NUM_CH*NUM_TERMS*REG_BITWIDTH-1:0] coef_r;
  logic [NUM_CH-1:0]                        en_r;
  logic signed [E_W-1:0]                    e1_r [NUM_CH];
  logic signed [E_W-1:0]                    e2_r [NUM_CH];
  logic signed [Y_W-1:0]                    y1_r [NUM_CH];
  logic signed [Y_W-1:0]                    y2_r [NUM_CH];
  logic [NUM_CH*E_W-1:0]                    out_r;
  logic                                     busy_r, done_r;

  int                                       ch_idx_s;
  logic signed [E_W-1:0]                    e_cur_s;
  logic signed [REG_BITWIDTH-1:0]           coef_sel_s;
  logic signed [Y_W-1:0]                    op_s, y_sat_s;
  logic                                     is_b_s, last_ch_s, last_term_s;

  // Operand selection for the current channel and term.
  always_comb begin
    ch_idx_s    = int'(ch_r);
    e_cur_s     = $signed({1'b0, set_r[ch_idx_s*ADC_BITWIDTH +: ADC_BITWIDTH]})
                - $signed({1'b0, adc_r[ch_idx_s*ADC_BITWIDTH +: ADC_BITWIDTH]});
    coef_sel_s  = coef_r[ch_idx_s*NUM_TERMS*REG_BITWIDTH + coef_lsb(term_r) +: REG_BITWIDTH];
    is_b_s      = (term_r < TERM_A1);
    last_ch_s   = (ch_r == CH_W'(NUM_CH - 1));
    last_term_s = (term_r == TERM_A0);
    case (term_r)
      TERM_B2: op_s = Y_W'(e_cur_s);
      TERM_B1: op_s = Y_W'(e1_r[ch_r]);
      TERM_B0: op_s = Y_W'(e2_r[ch_r]);
      TERM_A1: op_s = y1_r[ch_r];
      TERM_A0: op_s = y2_r[ch_r];
      default: op_s = {Y_W{1'b0}};
    endcase
  end

  pid_mac_sat u_mac_sat (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (state_r == ST_MAC),
    .clr_i   (term_r == TERM_B2),
    .is_b_i  (is_b_s),
    .coef_i  (coef_sel_s),
    .op_i    (op_s),
    .y_sat_o (y_sat_s)
  );

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: if (bus.start_i) state_s = ST_MAC;  else state_s = ST_IDLE;
      ST_MAC:  if (last_term_s) state_s = ST_WB;   else state_s = ST_MAC;
      ST_WB:   if (last_ch_s)   state_s = ST_DONE; else state_s = ST_MAC;
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM register, sequencing counters, handshake flags and input snapshot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      ch_r    <= {CH_W{1'b0}};
      term_r  <= TERM_B2;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      adc_r   <= {(NUM_CH*ADC_BITWIDTH){1'b0}};
      set_r   <= {(NUM_CH*ADC_BITWIDTH){1'b0}};
      coef_r  <= {(NUM_CH*NUM_TERMS*REG_BITWIDTH){1'b0}};
      en_r    <= {NUM_CH{1'b0}};
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_MAC) || (state_s == ST_WB);
      done_r  <= (state_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          ch_r   <= {CH_W{1'b0}};
          term_r <= TERM_B2;
          if (bus.start_i) begin
            adc_r  <= bus.ADC_value_i;
            set_r  <= bus.SET_value_i;
            coef_r <= bus.coef_i;
            en_r   <= bus.ch_en_i;
          end
        end
        ST_MAC:  term_r <= last_term_s ? TERM_B2 : (term_r + 3'd1);
        ST_WB:   ch_r   <= last_ch_s ? {CH_W{1'b0}} : (ch_r + 1'b1);
        default: ;
      endcase
    end
  end

  // Per-channel history and outputs; a disabled channel is wiped in its writeback slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        e1_r[c] <= {E_W{1'b0}};
        e2_r[c] <= {E_W{1'b0}};
        y1_r[c] <= {Y_W{1'b0}};
        y2_r[c] <= {Y_W{1'b0}};
      end
      out_r <= {(NUM_CH*E_W){1'b0}};
    end else if (state_r == ST_WB) begin
      if (en_r[ch_r]) begin
        e2_r[ch_r] <= e1_r[ch_r];
        e1_r[ch_r] <= e_cur_s;
        y2_r[ch_r] <= y1_r[ch_r];
        y1_r[ch_r] <= y_sat_s;
        out_r[ch_idx_s*E_W +: E_W] <= y_sat_s[Y_W-1:FRAC_BITWIDTH];
      end else begin
        e2_r[ch_r] <= {E_W{1'b0}};
        e1_r[ch_r] <= {E_W{1'b0}};
        y2_r[ch_r] <= {Y_W{1'b0}};
        y1_r[ch_r] <= {Y_W{1'b0}};
        out_r[ch_idx_s*E_W +: E_W] <= {E_W{1'b0}};
      end
    end
  end

  assign bus.busy_o    = busy_r;
  assign bus.done_o    = done_r;
  assign bus.out_Val_o = out_r;
  // Overrun must flag in the very cycle the rejected start arrives.
  assign bus.overrun_o = bus.start_i && (state_r != ST_IDLE);

endmodule

// File: tb/tb_pid_core_mc.sv
// Bench for pid_core_mc: run-level arithmetic model checked every cycle plus hand-computed spot values.
module tb_pid_core_mc;
  import pid_pkg::*;

  localparam int RUN_LEN = 6 * NUM_CH + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pid_core_mc_if bus_if();

  pid_core_mc dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  int m_y1[NUM_CH], m_y2[NUM_CH], m_e1[NUM_CH], m_e2[NUM_CH];
  int m_out[NUM_CH], m_new[NUM_CH];
  int pos = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] mk(input int a1, input int a0, input int b2, input int b1, input int b0);
    return {8'(a1), 8'(a0), 8'(b2), 8'(b1), 8'(b0)};
  endfunction

  function automatic int dut_out(input int c);
    logic [8:0] v;
    v = bus_if.out_Val_o[c*9 +: 9];
    return int'($signed(v));
  endfunction

  // One control-law step for channel c from the inputs present at the start edge.
  task automatic law(input int c);
    logic [39:0] cw;
    int a1, a0, b2, b1, b0, e, acc, yn;
    cw = bus_if.coef_i[c*40 +: 40];
    a1 = int'($signed(cw[39:32]));
    a0 = int'($signed(cw[31:24]));
    b2 = int'($signed(cw[23:16]));
    b1 = int'($signed(cw[15:8]));
    b0 = int'($signed(cw[7:0]));
    e  = int'(bus_if.SET_value_i[c*8 +: 8]) - int'(bus_if.ADC_value_i[c*8 +: 8]);
    if (!bus_if.ch_en_i[c]) begin
      m_e1[c] = 0; m_e2[c] = 0; m_y1[c] = 0; m_y2[c] = 0; m_new[c] = 0;
    end else begin
      acc = 8 * (b2 * e + b1 * m_e1[c] + b0 * m_e2[c]) - a1 * m_y1[c] - a0 * m_y2[c];
      yn  = acc >>> 3;
      if (yn > OUT_MAX * 8) yn = OUT_MAX * 8;
      if (yn < OUT_MIN * 8) yn = OUT_MIN * 8;
      m_e2[c] = m_e1[c]; m_e1[c] = e;
      m_y2[c] = m_y1[c]; m_y1[c] = yn;
      m_new[c] = yn >>> 3;
    end
  endtask

  // Model: run position since the accepted start, and when each channel's result becomes visible.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      pos = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_y1[c] = 0; m_y2[c] = 0; m_e1[c] = 0; m_e2[c] = 0; m_out[c] = 0; m_new[c] = 0;
      end
    end else if (pos == 0) begin
      if (bus_if.start_i) begin
        pos = 1;
        for (int c = 0; c < NUM_CH; c++) law(c);
      end
    end else begin
      pos = (pos == RUN_LEN) ? 0 : pos + 1;
      for (int c = 0; c < NUM_CH; c++)
        if (pos == 6 * (c + 1) + 1) m_out[c] = m_new[c];
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("busy",    int'(bus_if.busy_o),    int'(pos >= 1 && pos < RUN_LEN));
    chk("done",    int'(bus_if.done_o),    int'(pos == RUN_LEN));
    chk("overrun", int'(bus_if.overrun_o), int'(bus_if.start_i && pos != 0));
    for (int c = 0; c < NUM_CH; c++)
      chk($sformatf("out%0d", c), dut_out(c), m_out[c]);
  end

  task automatic cfg(input logic [39:0] c0, input logic [39:0] c1,
                     input int s0, input int a0, input int s1, input int a1, input logic [1:0] en);
    bus_if.coef_i      = {c1, c0};
    bus_if.SET_value_i = {8'(s1), 8'(s0)};
    bus_if.ADC_value_i = {8'(a1), 8'(a0)};
    bus_if.ch_en_i     = en;
  endtask

  task automatic run(input int ovr_at, input int rst_at, output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    @(posedge clk); #2;
    bus_if.start_i = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #2;
      bus_if.start_i = (k == ovr_at);
      if (k == rst_at) rst = 1'b1;
      @(negedge clk);
      if (bus_if.busy_o) bcnt++;
      if (k == ovr_at) chk("overrun_pulse", int'(bus_if.overrun_o), 1);
      if (k == rst_at) begin
        chk("rst_out0", dut_out(0), 0);
        chk("rst_out1", dut_out(1), 0);
        chk("rst_busy", int'(bus_if.busy_o), 0);
      end
      if (bus_if.done_o) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat, bc;

  initial begin
    bus_if.start_i = 1'b0;
    cfg(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), 0, 0, 0, 0, 2'b11);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(bus_if.busy_o), 0);
    chk("reset_out0", dut_out(0), 0);

    run(0, 0, lat, bc);
    chk("latency", lat, 13);
    chk("busy_cycles", bc, 12);
    chk("zero_out1", dut_out(1), 0);

    cfg(mk(0, 0, 8, 0, 0), mk(0, 0, 4, 0, 0), 100, 60, 100, 60, 2'b11);
    run(0, 0, lat, bc);
    chk("p_ch0", dut_out(0), 40);
    chk("p_ch1", dut_out(1), 20);

    cfg(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), 100, 60, 100, 60, 2'b00);
    run(0, 0, lat, bc);
    chk("dis_ch0", dut_out(0), 0);
    chk("dis_ch1", dut_out(1), 0);

    cfg(mk(-8, 0, 8, 0, 0), mk(0, 0, 0, 0, 0), 100, 60, 100, 60, 2'b11);
    for (int i = 1; i <= 7; i++) begin
      run(0, 0, lat, bc);
      chk($sformatf("integ_%0d", i), dut_out(0), (i < 7) ? 40 * i : 255);
    end
    cfg(mk(-8, 0, 8, 0, 0), mk(0, 0, 0, 0, 0), 60, 100, 100, 60, 2'b11);
    run(0, 0, lat, bc);
    chk("antiwindup", dut_out(0), 215);

    cfg(mk(0, 0, 8, 0, 0), mk(0, 0, 0, 0, 0), 0, 255, 100, 60, 2'b11);
    run(0, 0, lat, bc);
    chk("neg_ch0", dut_out(0), -255);
    cfg(mk(0, 0, 16, 0, 0), mk(0, 0, 0, 0, 0), 0, 255, 100, 60, 2'b11);
    run(0, 0, lat, bc);
    chk("neg_clamp", dut_out(0), -256);

    cfg(mk(0, 0, 8, 0, 0), mk(-8, 0, 8, 0, 0), 100, 60, 100, 60, 2'b11);
    run(0, 0, lat, bc);
    chk("en_ch1_a", dut_out(1), 40);
    run(0, 0, lat, bc);
    chk("en_ch1_b", dut_out(1), 80);
    cfg(mk(0, 0, 8, 0, 0), mk(-8, 0, 8, 0, 0), 100, 60, 100, 60, 2'b01);
    run(0, 0, lat, bc);
    chk("off_ch1", dut_out(1), 0);
    chk("off_ch0", dut_out(0), 40);
    cfg(mk(0, 0, 8, 0, 0), mk(-8, 0, 8, 0, 0), 100, 60, 100, 60, 2'b11);
    run(0, 0, lat, bc);
    chk("reen_ch1", dut_out(1), 40);

    run(3, 0, lat, bc);
    chk("ovr_latency", lat, 13);
    chk("ovr_ch1", dut_out(1), 80);

    run(0, 5, lat, bc);
    chk("rst_no_done", lat, 0);
    chk("rst_hold_out1", dut_out(1), 0);
    @(posedge clk); #2 rst = 1'b0;
    run(0, 0, lat, bc);
    chk("post_rst_lat", lat, 13);
    chk("post_rst_ch1", dut_out(1), 40);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
